// File: rtl/sys_arr_pkg.sv
// -----------------------------------------------------------------------------
// sys_arr_pkg
// Shared constants and types for the systolic array slice: the PE data width,
// the per-column partial-sum width and a signed sum type. The PE, the row and
// the output collector all import this package so that widths stay in step.
// -----------------------------------------------------------------------------
package sys_arr_pkg;

    // Width of the operands streamed into each PE.
    localparam int DATA_W = 8;

    // Width of one column's partial sum as it leaves the bottom row.
    localparam int SUM_W = 16;

    // A column partial sum, interpreted as two's complement.
    typedef logic signed [SUM_W-1:0] sum_t;

    // Clamp a negative partial sum to zero and pass non-negative sums through.
    function automatic sum_t relu(input sum_t s);
        return s[SUM_W-1] ? '0 : s;
    endfunction

endpackage

// File: rtl/sys_arr_sync_fifo.sv
// -----------------------------------------------------------------------------
// sys_arr_sync_fifo
// Single-clock FIFO that holds aligned result vectors until downstream
// writeback accepts them. DEPTH must be a power of two so that the pointers
// wrap for free.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset; empties the FIFO and zeroes storage
//   push_i   in   write data_i at the tail (ignored when full without a pop)
//   pop_i    in   drop the head entry (ignored when empty)
//   data_i   in   WIDTH-bit entry to write
//   data_o   out  entry at the head (mem[rd_ptr])
//   full_o   out  occupancy equals DEPTH
//   empty_o  out  occupancy equals zero
//   count_o  out  current occupancy
// -----------------------------------------------------------------------------
module sys_arr_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush;
    logic             doPop;

    // Status flags come straight from the occupancy counter.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rdPtr_q];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still allowed when it is paired with a pop.
    always_comb begin
        doPop   = pop_i && !empty_o;
        doPush  = push_i && (!full_o || doPop);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/sys_arr_collector.sv
// -----------------------------------------------------------------------------
// sys_arr_collector
// Output-side reader for the systolic array. Column i of the bottom row
// produces its result i cycles after column 0, so each column is delayed by
// (row_width-1-i) registers to line the vector back up. Complete vectors are
// buffered in a FIFO and offered downstream on a ready/valid handshake.
//
// Optional feature: define SYS_ARR_COLLECTOR_RELU_EN to clamp negative
// (signed) column sums to zero before they are written into the FIFO.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   synchronous active-high reset; discards everything in flight
//   activein     in   per-column valid from the bottom row, bit 0 = leftmost column
//   sumin        in   per-column partial sums, column 0 in the LSBs
//   resultout    out  aligned vector at the FIFO head, column 0 in the LSBs
//   resultvalid  out  FIFO holds at least one vector
//   resultready  in   downstream takes the head when high together with resultvalid
//   count        out  FIFO occupancy
//   overflow     out  sticky: a complete vector was dropped because the FIFO was full
//   skew_err     out  sticky: an aligned slot had some but not all valids set
// -----------------------------------------------------------------------------
module sys_arr_collector
    import sys_arr_pkg::*;
#(
    parameter int row_width  = 2,
    parameter int fifo_depth = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [row_width-1:0]            activein,
    input  logic [SUM_W*row_width-1:0]      sumin,
    output logic [SUM_W*row_width-1:0]      resultout,
    output logic                            resultvalid,
    input  logic                            resultready,
    output logic [$clog2(fifo_depth+1)-1:0] count,
    output logic                            overflow,
    output logic                            skew_err
);

    localparam int VEC_W = SUM_W * row_width;

    logic [row_width-1:0] alignedValid;
    logic [VEC_W-1:0]     alignedSum;
    logic [VEC_W-1:0]     writeData;
    logic                 slotFull;
    logic                 slotPartial;
    logic                 popReq;
    logic                 pushReq;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 overflow_q, overflow_d;
    logic                 skewErr_q, skewErr_d;

    // De-skew delay lines. The rightmost column arrives last and feeds the
    // aligned slot directly; every column to its left waits one extra
    // register per column of distance so that all columns meet together.
    for (genvar col = 0; col < row_width; col++) begin : g_deskew
        localparam int DLY = row_width - 1 - col;
        if (DLY == 0) begin : g_pass
            assign alignedValid[col]               = activein[col];
            assign alignedSum[col*SUM_W +: SUM_W]  = sumin[col*SUM_W +: SUM_W];
        end else begin : g_delay
            logic [DLY-1:0]   valid_q;
            logic [SUM_W-1:0] sum_q [DLY];

            // Shift the column's valid and sum one stage per cycle; reset
            // clears the valids so a half-formed vector cannot survive.
            always_ff @(posedge clock) begin
                if (reset) begin
                    valid_q <= '0;
                    for (int s = 0; s < DLY; s++) begin
                        sum_q[s] <= '0;
                    end
                end else begin
                    valid_q[0] <= activein[col];
                    sum_q[0]   <= sumin[col*SUM_W +: SUM_W];
                    for (int s = 1; s < DLY; s++) begin
                        valid_q[s] <= valid_q[s-1];
                        sum_q[s]   <= sum_q[s-1];
                    end
                end
            end

            assign alignedValid[col]              = valid_q[DLY-1];
            assign alignedSum[col*SUM_W +: SUM_W] = sum_q[DLY-1];
        end
    end

`ifdef SYS_ARR_COLLECTOR_RELU_EN
    // Each column is clamped independently on its way into the FIFO, so the
    // pipeline depth does not change.
    for (genvar col = 0; col < row_width; col++) begin : g_relu
        assign writeData[col*SUM_W +: SUM_W] = relu(sum_t'(alignedSum[col*SUM_W +: SUM_W]));
    end
`else
    assign writeData = alignedSum;
`endif

    // Classify the aligned slot and decide whether the FIFO takes it. A full
    // FIFO still accepts a vector when the head leaves in the same cycle;
    // otherwise the vector is dropped and remembered as an overflow.
    always_comb begin
        slotFull    = &alignedValid;
        slotPartial = (|alignedValid) && !slotFull;
        popReq      = resultvalid && resultready;
        pushReq     = slotFull && (!fifoFull || popReq);
        overflow_d  = overflow_q | (slotFull && fifoFull && !popReq);
        skewErr_d   = skewErr_q | slotPartial;
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_q <= 1'b0;
            skewErr_q  <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            skewErr_q  <= skewErr_d;
        end
    end

    sys_arr_sync_fifo #(
        .WIDTH (VEC_W),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (pushReq),
        .pop_i   (popReq),
        .data_i  (writeData),
        .data_o  (resultout),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (count)
    );

    assign resultvalid = !fifoEmpty;
    assign overflow    = overflow_q;
    assign skew_err    = skewErr_q;

endmodule
